// File: rtl/dpram16_port_arbiter.sv
// Arbitrates RAM port B between the CPU data bus (M0) and the debug loader (M1).
// Define DPRAM_ARB_RR_EN for round-robin arbitration instead of fixed M0 priority with starvation escape.
module dpram16_port_arbiter #(
   parameter int DATA   = 16,
   parameter int ADDR   = 11,
   parameter int STARVE = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            m0_req,
   input  logic            m0_we,
   input  logic [ADDR-1:0] m0_addr,
   input  logic [DATA-1:0] m0_wdata,
   input  logic            m1_req,
   input  logic            m1_we,
   input  logic [ADDR-1:0] m1_addr,
   input  logic [DATA-1:0] m1_wdata,
   input  logic            m1_lock,
   output logic            m0_ack,
   output logic            m1_ack,
   output logic            m0_rvalid,
   output logic            m1_rvalid,
   output logic [DATA-1:0] m0_rdata,
   output logic [DATA-1:0] m1_rdata,
   output logic            b_ce,
   output logic            b_we,
   output logic [ADDR-1:0] b_addr,
   output logic [DATA-1:0] b_write,
   input  logic [DATA-1:0] b_read
);

`ifndef DPRAM_ARB_RR_EN
   localparam logic [7:0] STARVE_C = 8'(STARVE);
   logic [7:0] waitCnt_q, waitCnt_d;
`endif
   logic            lastGrant_q, lastGrant_d;
   logic            locked_q, locked_d;
   logic            rdPendM0_q, rdPendM0_d;
   logic            rdPendM1_q, rdPendM1_d;
   logic [DATA-1:0] rdataM0_q, rdataM1_q;
   logic            m1Wins, gnt0, gnt1;

   // Grants are gated by rst_n so the RAM port goes quiet the instant reset asserts.
   always_comb begin
`ifdef DPRAM_ARB_RR_EN
      m1Wins = locked_q || !lastGrant_q;
`else
      m1Wins = locked_q || (waitCnt_q == STARVE_C);
`endif
      gnt1 = rst_n && m1_req && (!m0_req || m1Wins);
      gnt0 = rst_n && m0_req && !gnt1;
   end

   always_comb begin
      b_ce    = gnt0 || gnt1;
      b_we    = 1'b0;
      b_addr  = '0;
      b_write = '0;
      if (gnt1) begin
         b_we    = m1_we;
         b_addr  = m1_addr;
         b_write = m1_wdata;
      end else if (gnt0) begin
         b_we    = m0_we;
         b_addr  = m0_addr;
         b_write = m0_wdata;
      end
   end

   always_comb begin
      lastGrant_d = lastGrant_q;
      if (gnt1)
         lastGrant_d = 1'b1;
      else if (gnt0)
         lastGrant_d = 1'b0;

      locked_d = locked_q;
      if (gnt1 && m1_lock)
         locked_d = 1'b1;
      else if (!m1_lock || !m1_req)
         locked_d = 1'b0;

`ifndef DPRAM_ARB_RR_EN
      waitCnt_d = waitCnt_q;
      if (!m1_req || gnt1)
         waitCnt_d = '0;
      else if (waitCnt_q != STARVE_C)
         waitCnt_d = waitCnt_q + 8'd1;
`endif

      rdPendM0_d = gnt0 && !m0_we;
      rdPendM1_d = gnt1 && !m1_we;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lastGrant_q <= 1'b1;
         locked_q    <= 1'b0;
`ifndef DPRAM_ARB_RR_EN
         waitCnt_q   <= '0;
`endif
         rdPendM0_q  <= 1'b0;
         rdPendM1_q  <= 1'b0;
         rdataM0_q   <= '0;
         rdataM1_q   <= '0;
      end else begin
         lastGrant_q <= lastGrant_d;
         locked_q    <= locked_d;
`ifndef DPRAM_ARB_RR_EN
         waitCnt_q   <= waitCnt_d;
`endif
         rdPendM0_q  <= rdPendM0_d;
         rdPendM1_q  <= rdPendM1_d;
         if (rdPendM0_q)
            rdataM0_q <= b_read;
         if (rdPendM1_q)
            rdataM1_q <= b_read;
      end
   end

   // Read data arrives from the RAM the cycle after the ack; otherwise the last value is held.
   assign m0_ack    = gnt0;
   assign m1_ack    = gnt1;
   assign m0_rvalid = rdPendM0_q;
   assign m1_rvalid = rdPendM1_q;
   assign m0_rdata  = rdPendM0_q ? b_read : rdataM0_q;
   assign m1_rdata  = rdPendM1_q ? b_read : rdataM1_q;

endmodule

// File: tb/tb_dpram16_port_arbiter.sv
// Directed bench for dpram16_port_arbiter with a port-B RAM model and read-data scoreboard.
module tb_dpram16_port_arbiter;

   logic        clk;
   logic        rst_n;
   logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
   logic [10:0] m0_addr, m1_addr;
   logic [15:0] m0_wdata, m1_wdata;
   logic        m0_ack, m1_ack, m0_rvalid, m1_rvalid;
   logic [15:0] m0_rdata, m1_rdata;
   logic        b_ce, b_we;
   logic [10:0] b_addr;
   logic [15:0] b_write, b_read;

   int checks = 0;
   int errors = 0;

   logic [15:0] ram [0:2047];
   logic [15:0] refMem [0:2047];
   logic [10:0] ramAddrQ;
   logic [15:0] q0 [$];
   logic [15:0] q1 [$];
   logic        pend0 = 1'b0;
   logic        pend1 = 1'b0;

   dpram16_port_arbiter #(.DATA(16), .ADDR(11), .STARVE(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_lock(m1_lock),
      .m0_ack(m0_ack), .m1_ack(m1_ack), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
      .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
      .b_ce(b_ce), .b_we(b_we), .b_addr(b_addr), .b_write(b_write), .b_read(b_read)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Port-B RAM with registered address; a write followed by a read returns the new word.
   initial begin
      ramAddrQ = '0;
      for (int i = 0; i < 2048; i++) begin
         ram[i]    = 16'(i * 16'h0101) ^ 16'h5A3C;
         refMem[i] = 16'(i * 16'h0101) ^ 16'h5A3C;
      end
   end
   always @(posedge clk) begin
      if (b_ce) begin
         if (b_we) ram[b_addr] <= b_write;
         ramAddrQ <= b_addr;
      end
   end
   assign b_read = ram[ramAddrQ];

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Checks read returns owed from the previous cycle, then this cycle's grant and port-B drive.
   task automatic checkCycle(input logic e0, input logic e1, input string tag);
      logic [28:0] expB;
      checkOutput({tag, " m0_rvalid"}, 32'(m0_rvalid), 32'(pend0));
      if (pend0) checkOutput({tag, " m0_rdata"}, 32'(m0_rdata), 32'(q0.pop_front()));
      checkOutput({tag, " m1_rvalid"}, 32'(m1_rvalid), 32'(pend1));
      if (pend1) checkOutput({tag, " m1_rdata"}, 32'(m1_rdata), 32'(q1.pop_front()));
      checkOutput({tag, " m0_ack"}, 32'(m0_ack), 32'(e0));
      checkOutput({tag, " m1_ack"}, 32'(m1_ack), 32'(e1));
      if (e1)      expB = {1'b1, m1_we, m1_addr, m1_wdata};
      else if (e0) expB = {1'b1, m0_we, m0_addr, m0_wdata};
      else         expB = '0;
      checkOutput({tag, " port_b"}, 32'({b_ce, b_we, b_addr, b_write}), 32'(expB));
      pend0 = e0 && !m0_we;
      pend1 = e1 && !m1_we;
      if (pend0) q0.push_back(refMem[m0_addr]);
      if (pend1) q1.push_back(refMem[m1_addr]);
      if (e0 && m0_we) refMem[m0_addr] = m0_wdata;
      if (e1 && m1_we) refMem[m1_addr] = m1_wdata;
   endtask

   task automatic applyStimulus(input logic r0, input logic w0, input logic [10:0] a0, input logic [15:0] d0,
                                input logic r1, input logic w1, input logic [10:0] a1, input logic [15:0] d1,
                                input logic lk, input logic e0, input logic e1, input string tag);
      @(posedge clk);
      #1;
      m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
      m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
      m1_lock = lk;
      @(negedge clk);
      checkCycle(e0, e1, tag);
   endtask

   task automatic idleCycle(input string tag);
      applyStimulus(0, 0, 11'h0, 16'h0, 0, 0, 11'h0, 16'h0, 0, 0, 0, tag);
   endtask

   task automatic checkAllReset(input string tag);
      checkOutput({tag, " flags"}, 32'({m0_ack, m1_ack, m0_rvalid, m1_rvalid, b_ce, b_we}), 32'h0);
      checkOutput({tag, " m0_rdata"}, 32'(m0_rdata), 32'h0);
      checkOutput({tag, " m1_rdata"}, 32'(m1_rdata), 32'h0);
      checkOutput({tag, " b_addr_write"}, 32'({b_addr, b_write}), 32'h0);
   endtask

   initial begin
      rst_n = 1'b0;
      m0_req = 1'b1; m0_we = 1'b0; m0_addr = 11'h005; m0_wdata = 16'h0;
      m1_req = 1'b1; m1_we = 1'b1; m1_addr = 11'h006; m1_wdata = 16'h1111;
      m1_lock = 1'b0;
      #12;
      checkAllReset("por");
      m0_req = 1'b0; m1_req = 1'b0; m1_we = 1'b0; m1_wdata = 16'h0; m0_addr = '0; m1_addr = '0;
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] M0 write then read 0x010");
      applyStimulus(1, 1, 11'h010, 16'hBEEF, 0, 0, 11'h0, 16'h0, 0, 1, 0, "wrBeef");
      applyStimulus(1, 0, 11'h010, 16'h0, 0, 0, 11'h0, 16'h0, 0, 1, 0, "rdBeef");
      idleCycle("rdBeefRet");

      $display("[TB] reset during a pending read");
      applyStimulus(1, 0, 11'h010, 16'h0, 0, 0, 11'h0, 16'h0, 0, 1, 0, "rdMid");
      #1 rst_n = 1'b0;
      #1 checkAllReset("midRst");
      pend0 = 1'b0;
      q0.delete();
      applyStimulus(1, 0, 11'h010, 16'h0, 1, 0, 11'h020, 16'h0, 0, 0, 0, "inRst");
      m0_req = 1'b0; m1_req = 1'b0;
      #1 rst_n = 1'b1;
      idleCycle("postRst0");
      idleCycle("postRst1");

`ifdef DPRAM_ARB_RR_EN
      $display("[TB] round-robin alternation");
      for (int i = 0; i < 6; i++)
         applyStimulus(1, 0, 11'h020, 16'h0, 1, 0, 11'h030, 16'h0, 0, (i % 2) == 0, (i % 2) == 1, "rr");
`else
      $display("[TB] fixed priority with starvation escape");
      for (int i = 0; i < 18; i++)
         applyStimulus(1, 0, 11'h020, 16'h0, 1, 0, 11'h030, 16'h0, 0, (i % 9) != 8, (i % 9) == 8, "starve");
`endif
      idleCycle("arbDrain");

      $display("[TB] M1 locked write burst");
      applyStimulus(0, 0, 11'h0,   16'h0, 1, 1, 11'h100, 16'hC100, 1, 0, 1, "lockA");
      applyStimulus(1, 0, 11'h010, 16'h0, 1, 1, 11'h101, 16'hC101, 1, 0, 1, "lockB");
      applyStimulus(1, 0, 11'h010, 16'h0, 1, 1, 11'h102, 16'hC102, 1, 0, 1, "lockC");
      applyStimulus(1, 0, 11'h010, 16'h0, 1, 1, 11'h103, 16'hC103, 1, 0, 1, "lockD");
      applyStimulus(1, 0, 11'h010, 16'h0, 0, 0, 11'h0,   16'h0,    1, 1, 0, "lockRel");
`ifdef DPRAM_ARB_RR_EN
      applyStimulus(1, 0, 11'h101, 16'h0, 1, 0, 11'h102, 16'h0, 0, 0, 1, "postLock");
      applyStimulus(1, 0, 11'h101, 16'h0, 0, 0, 11'h0,   16'h0, 0, 1, 0, "postLock2");
`else
      applyStimulus(1, 0, 11'h101, 16'h0, 1, 0, 11'h102, 16'h0, 0, 1, 0, "postLock");
      applyStimulus(0, 0, 11'h0,   16'h0, 1, 0, 11'h102, 16'h0, 0, 0, 1, "postLock2");
`endif
      applyStimulus(0, 0, 11'h0, 16'h0, 1, 0, 11'h103, 16'h0, 0, 0, 1, "rd103");
      idleCycle("lockDrain");

      $display("[TB] boundary addresses back to back");
      applyStimulus(1, 0, 11'h7FF, 16'h0, 0, 0, 11'h0,   16'h0, 0, 1, 0, "rdTop");
      applyStimulus(0, 0, 11'h0,   16'h0, 1, 0, 11'h000, 16'h0, 0, 0, 1, "rdBottom");
      idleCycle("edgeDrain");

      $display("[TB] cross-master write then read");
      applyStimulus(1, 1, 11'h055, 16'h1234, 0, 0, 11'h0,   16'h0, 0, 1, 0, "xWr");
      applyStimulus(0, 0, 11'h0,   16'h0,    1, 0, 11'h055, 16'h0, 0, 0, 1, "xRd");
      idleCycle("xDrain");
      idleCycle("final");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
